// File: rtl/bank_fifo_write_arbiter_pkg.sv
// Shared definitions for the bank FIFO write arbiter: state encoding and sizing helpers.
package bank_fifo_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StXfer = 2'd1,
    StPad  = 2'd2
  } state_e;

  function automatic int unsigned bank_words(int unsigned n);
    return 32'd1 << (n - 1);
  endfunction

  // Width needed to hold indices 0..v-1, never less than one bit.
  function automatic int unsigned clog2_min1(int unsigned v);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/bank_fifo_write_arbiter_rr_picker.sv
// Combinational round-robin select: first asserted request at or after ptr, cyclically.
module rr_picker #(
  parameter int unsigned REQ_N = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [REQ_N-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [REQ_N-1:0] pick,
  output logic             found
);

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < REQ_N; off++) begin
      for (int unsigned i = 0; i < REQ_N; i++) begin
        if (!found && req[i] && (((32'(ptr) + off) % REQ_N) == i)) begin
          pick[i] = 1'b1;
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bank_fifo_write_arbiter.sv
// Grants one producer a whole FIFO bank at a time, round-robin at bank granularity.
// Optional early-end padding is built with BANK_FIFO_WRITE_ARBITER_PAD_EN.
module bank_fifo_write_arbiter
  import bank_fifo_pkg::*;
#(
  parameter int unsigned REQ_N    = 2,
  parameter int unsigned W        = 16,
  parameter int unsigned N        = 8,
  parameter logic [W-1:0] PAD_WORD = '0
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic [REQ_N-1:0]   req_valid,
  input  logic [REQ_N-1:0]   req_last,
  input  logic [REQ_N*W-1:0] req_data,
  output logic [REQ_N-1:0]   req_ready,
  output logic [REQ_N-1:0]   grant,
  output logic               busy,
  output logic               fifo_trigger,
  output logic [W-1:0]       fifo_data,
  input  logic               fifo_done,
  output logic [7:0]         banks_written
);

  localparam int unsigned PTR_W      = clog2_min1(REQ_N);
  localparam int unsigned CNT_W      = N - 1;
  localparam int unsigned BANK_WORDS = bank_words(N);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BANK_WORDS - 1);

  state_e           state_q, state_d;
  logic [REQ_N-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       banks_q, banks_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  logic [REQ_N-1:0] pick;
  logic             found;
  logic             g_valid;
  logic [W-1:0]     g_data;
  logic [PTR_W-1:0] g_next;
  logic             accept;
  logic             bank_done;

  rr_picker #(
    .REQ_N(REQ_N),
    .PTR_W(PTR_W)
  ) u_picker (
    .req  (req_valid),
    .ptr  (ptr_q),
    .pick (pick),
    .found(found)
  );

  // Owner's lane and the pointer value that follows it.
  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    g_next  = '0;
    for (int unsigned i = 0; i < REQ_N; i++) begin
      if (grant_q[i]) begin
        g_valid = req_valid[i];
        g_data  = req_data[i*W +: W];
        g_next  = PTR_W'((i + 1) % REQ_N);
      end
    end
  end

  // fifo_trigger is a function of state and valid only, so fifo_done cannot loop back.
  always_comb begin
    fifo_trigger = 1'b0;
    fifo_data    = '0;
    req_ready    = '0;
    case (state_q)
      StXfer: begin
        fifo_trigger = g_valid;
        fifo_data    = g_data;
        req_ready    = grant_q & {REQ_N{fifo_done & g_valid}};
      end
`ifdef BANK_FIFO_WRITE_ARBITER_PAD_EN
      StPad: begin
        fifo_trigger = 1'b1;
        fifo_data    = PAD_WORD;
      end
`endif
      default: ;
    endcase
  end

  assign accept    = fifo_trigger & fifo_done;
  assign bank_done = accept & (cnt_q == CNT_MAX);

`ifdef BANK_FIFO_WRITE_ARBITER_PAD_EN
  logic g_last;
  assign g_last = |(grant_q & req_last);
`else
  logic unused_pad_inputs;
  assign unused_pad_inputs = ^{req_last, PAD_WORD};
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    banks_d = banks_q;
    ptr_d   = ptr_q;
    // Counter is exactly bank-sized, so it wraps to zero on the last word.
    if (accept) cnt_d = cnt_q + 1'b1;
    if (bank_done) begin
      banks_d = banks_q + 8'd1;
      ptr_d   = g_next;
      grant_d = '0;
      state_d = StIdle;
    end else if (state_q == StIdle && found) begin
      grant_d = pick;
      state_d = StXfer;
    end
`ifdef BANK_FIFO_WRITE_ARBITER_PAD_EN
    else if (state_q == StXfer && accept && g_last) begin
      state_d = StPad;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= StIdle;
      grant_q <= '0;
      cnt_q   <= '0;
      banks_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      banks_q <= banks_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant         = grant_q;
  assign busy          = (state_q != StIdle);
  assign banks_written = banks_q;

endmodule

// File: tb/tb_bank_fifo_write_arbiter.sv
// Scoreboard bench for bank_fifo_write_arbiter with N=4 (8-word banks) and two producers.
module tb_bank_fifo_write_arbiter;

  localparam logic [15:0] PAD = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst_;
  logic [1:0]  req_valid, req_last, req_ready, grant;
  logic [31:0] req_data;
  logic        busy, fifo_trigger, fifo_done;
  logic [15:0] fifo_data;
  logic [7:0]  banks_written;

  logic [1:0]  en, last_en;
  logic        done_en;
  logic [11:0] seq [2];

  typedef struct packed {
    logic [1:0]  gnt;
    logic [1:0]  rdy;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t got_q[$];
  wr_t mon;
  int  checks = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  bank_fifo_write_arbiter #(
    .REQ_N   (2),
    .W       (16),
    .N       (4),
    .PAD_WORD(PAD)
  ) dut (
    .clk          (clk),
    .rst_         (rst_),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .grant        (grant),
    .busy         (busy),
    .fifo_trigger (fifo_trigger),
    .fifo_data    (fifo_data),
    .fifo_done    (fifo_done),
    .banks_written(banks_written)
  );

  // FIFO model: accepts whenever triggered unless the bench holds done low.
  assign fifo_done = fifo_trigger & done_en;

  // Producers: word = {source, sequence}; an enabled last marks sequence 3 as the final word.
  for (genvar gi = 0; gi < 2; gi++) begin : g_prod
    assign req_valid[gi] = en[gi] & ~(last_en[gi] & (seq[gi] > 12'd3));
    assign req_last[gi]  = last_en[gi] & (seq[gi] == 12'd3);
    assign req_data[gi*16 +: 16] = {4'(gi), seq[gi]};
  end

  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      seq[0] <= 12'd0;
      seq[1] <= 12'd0;
    end else begin
      for (int i = 0; i < 2; i++) if (req_ready[i]) seq[i] <= seq[i] + 12'd1;
    end
  end

  always @(negedge clk) begin
    if (rst_ === 1'b1 && fifo_trigger && fifo_done) begin
      mon.gnt  = grant;
      mon.rdy  = req_ready;
      mon.data = fifo_data;
      got_q.push_back(mon);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    en = 2'b00; last_en = 2'b00; done_en = 1'b1;
    rst_ = 1'b0;
    tick(); tick();
    rst_ = 1'b1;
    tick();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic push_words(input int src, input int first, input int cnt);
    wr_t w;
    for (int k = 0; k < cnt; k++) begin
      w.gnt  = 2'(1 << src);
      w.rdy  = 2'(1 << src);
      w.data = {4'(src), 12'(first + k)};
      exp_q.push_back(w);
    end
  endtask

  task automatic push_pad(input int src, input int cnt);
    wr_t w;
    for (int k = 0; k < cnt; k++) begin
      w.gnt  = 2'(1 << src);
      w.rdy  = 2'b00;
      w.data = PAD;
      exp_q.push_back(w);
    end
  endtask

  task automatic wait_banks(input int target, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (banks_written == 8'(target)) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic wait_words(input int target, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (got_q.size() == target) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({grant, busy, req_ready, fifo_trigger, fifo_data, banks_written} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: grant=%b busy=%b rdy=%b trig=%b data=%h banks=%0d, required all 0",
               grant, busy, req_ready, fifo_trigger, fifo_data, banks_written);
    end
  endtask

  task automatic test_single();
    bit ok;
    wr_t e, g;
    en = 2'b01;
    tick();
    checks++;
    if (grant !== 2'b01) begin
      failures++; $display("FAIL single_grant_latency: grant=%b required 01", grant);
    end
    push_words(0, 0, 8);
    wait_banks(1, ok);
    checks++;
    if (!ok || grant !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_bank_end: banks=%0d grant=%b busy=%b required 1/00/0",
               banks_written, grant, busy);
    end
    en = 2'b00;
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        failures++; $display("FAIL single_words: missing write, required %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          failures++; $display("FAIL single_words: got %h required %h", g, e);
        end
      end
    end
    checks++;
    if (got_q.size() != 0) begin
      failures++; $display("FAIL single_extra: %0d extra writes, required 0", got_q.size());
    end
  endtask

  task automatic test_alternate();
    int prev;
    wr_t e, g;
    apply_reset();
    en = 2'b11;
    push_words(0, 0, 8);
    push_words(1, 0, 8);
    push_words(0, 8, 8);
    prev = 0;
    for (int c = 0; c < 300 && prev < 3; c++) begin
      tick();
      if (int'(banks_written) != prev) begin
        prev = int'(banks_written);
        checks++;
        if (grant !== 2'b00) begin
          failures++; $display("FAIL alt_idle_gap: grant=%b after bank %0d, required 00", grant, prev);
        end
      end
    end
    en = 2'b00;
    checks++;
    if (prev != 3) begin
      failures++; $display("FAIL alt_timeout: banks=%0d required 3", prev);
    end
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        failures++; $display("FAIL alt_words: missing write, required %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          failures++; $display("FAIL alt_words: got %h required %h", g, e);
        end
      end
    end
    checks++;
    if (got_q.size() != 0) begin
      failures++; $display("FAIL alt_extra: %0d extra writes, required 0", got_q.size());
    end
  endtask

  task automatic test_reset_mid_xfer();
    bit ok;
    wr_t e, g;
    en = 2'b01;
    wait_words(5, ok);
    rst_ = 1'b0;
    #1;
    checks++;
    if (!ok || {grant, busy, req_ready, fifo_trigger, fifo_data, banks_written} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: ok=%0d grant=%b busy=%b rdy=%b trig=%b data=%h banks=%0d, required 1/all 0",
               ok, grant, busy, req_ready, fifo_trigger, fifo_data, banks_written);
    end
    en = 2'b00;
    exp_q.delete();
    got_q.delete();
    tick();
    rst_ = 1'b1;
    tick();
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      failures++; $display("FAIL midreset_idle: grant=%b busy=%b required 00/0", grant, busy);
    end
    en = 2'b01;
    push_words(0, 0, 8);
    wait_banks(1, ok);
    en = 2'b00;
    checks++;
    if (!ok) begin
      failures++; $display("FAIL midreset_bank: banks=%0d required 1", banks_written);
    end
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        failures++; $display("FAIL midreset_words: missing write, required %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          failures++; $display("FAIL midreset_words: got %h required %h", g, e);
        end
      end
    end
    checks++;
    if (got_q.size() != 0) begin
      failures++; $display("FAIL midreset_extra: %0d extra writes, required 0", got_q.size());
    end
  endtask

  task automatic test_done_stall();
    bit ok;
    wr_t e, g;
    apply_reset();
    en = 2'b01;
    push_words(0, 0, 8);
    wait_words(4, ok);
    done_en = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (!ok || fifo_data !== 16'h0004 || req_ready !== 2'b00 || fifo_trigger !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold: cycle %0d data=%h rdy=%b trig=%b, required 0004/00/1",
                 c, fifo_data, req_ready, fifo_trigger);
      end
      tick();
    end
    done_en = 1'b1;
    wait_banks(1, ok);
    en = 2'b00;
    checks++;
    if (!ok) begin
      failures++; $display("FAIL stall_bank: banks=%0d required 1", banks_written);
    end
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        failures++; $display("FAIL stall_words: missing write, required %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          failures++; $display("FAIL stall_words: got %h required %h", g, e);
        end
      end
    end
    checks++;
    if (got_q.size() != 0) begin
      failures++; $display("FAIL stall_extra: %0d extra writes, required 0", got_q.size());
    end
  endtask

  task automatic test_drop_valid();
    bit ok;
    wr_t e, g;
    apply_reset();
    en = 2'b10;
    tick();
    checks++;
    if (grant !== 2'b10) begin
      failures++; $display("FAIL drop_first_grant: grant=%b required 10", grant);
    end
    push_words(1, 0, 8);
    push_words(0, 0, 8);
    wait_words(2, ok);
    en = 2'b01;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (!ok || grant !== 2'b10 || fifo_trigger !== 1'b0) begin
        failures++;
        $display("FAIL drop_hold: cycle %0d grant=%b trig=%b, required 10/0", c, grant, fifo_trigger);
      end
    end
    en = 2'b11;
    wait_banks(1, ok);
    wait_banks(2, ok);
    en = 2'b00;
    checks++;
    if (!ok) begin
      failures++; $display("FAIL drop_banks: banks=%0d required 2", banks_written);
    end
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        failures++; $display("FAIL drop_words: missing write, required %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          failures++; $display("FAIL drop_words: got %h required %h", g, e);
        end
      end
    end
    checks++;
    if (got_q.size() != 0) begin
      failures++; $display("FAIL drop_extra: %0d extra writes, required 0", got_q.size());
    end
  endtask

  task automatic test_pad();
    bit ok;
    wr_t e, g;
    apply_reset();
    en = 2'b01;
    last_en = 2'b01;
    push_words(0, 0, 4);
`ifdef BANK_FIFO_WRITE_ARBITER_PAD_EN
    push_pad(0, 4);
    wait_banks(1, ok);
    checks++;
    if (!ok || grant !== 2'b00) begin
      failures++; $display("FAIL pad_bank: banks=%0d grant=%b required 1/00", banks_written, grant);
    end
`else
    wait_words(4, ok);
    repeat (10) tick();
    checks++;
    if (!ok || grant !== 2'b01 || busy !== 1'b1 || fifo_trigger !== 1'b0 || banks_written !== 8'd0) begin
      failures++;
      $display("FAIL nopad_stall: grant=%b busy=%b trig=%b banks=%0d, required 01/1/0/0",
               grant, busy, fifo_trigger, banks_written);
    end
`endif
    en = 2'b00;
    last_en = 2'b00;
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        failures++; $display("FAIL pad_words: missing write, required %h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          failures++; $display("FAIL pad_words: got %h required %h", g, e);
        end
      end
    end
    checks++;
    if (got_q.size() != 0) begin
      failures++; $display("FAIL pad_extra: %0d extra writes, required 0", got_q.size());
    end
    apply_reset();
  endtask

  initial begin
    rst_ = 1'b0;
    en = 2'b00;
    last_en = 2'b00;
    done_en = 1'b1;
    test_reset();
    test_single();
    test_alternate();
    test_reset_mid_xfer();
    test_done_stall();
    test_drop_valid();
    test_pad();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
